// File: rtl/l2_adaptor_pkg.sv
// Shared constants and FSM state encoding for the L2 physical-memory burst adaptor.
package l2_adaptor_pkg;

    localparam int unsigned LINE_WIDTH  = 256;
    localparam int unsigned BURST_WIDTH = 64;
    localparam int unsigned BEATS       = LINE_WIDTH / BURST_WIDTH;
    localparam int unsigned CNT_W       = 2;
    localparam int unsigned ADDR_W      = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } adaptor_state_e;

endpackage

// File: rtl/l2_cacheline_adaptor_if.sv
// L2-side and memory-side signals of the cache-line burst adaptor.
interface l2_cacheline_adaptor_if;
    import l2_adaptor_pkg::*;

    logic [LINE_WIDTH-1:0]  line_i;
    logic [LINE_WIDTH-1:0]  line_o;
    logic [ADDR_W-1:0]      address_i;
    logic                   read_i;
    logic                   write_i;
    logic                   resp_o;
    logic [BURST_WIDTH-1:0] burst_i;
    logic [BURST_WIDTH-1:0] burst_o;
    logic [ADDR_W-1:0]      address_o;
    logic                   read_o;
    logic                   write_o;
    logic                   resp_i;

    // Adaptor view
    modport slave (
        input  line_i, address_i, read_i, write_i, burst_i, resp_i,
        output line_o, resp_o, burst_o, address_o, read_o, write_o
    );

    // Environment view (L2 + memory model)
    modport master (
        output line_i, address_i, read_i, write_i, burst_i, resp_i,
        input  line_o, resp_o, burst_o, address_o, read_o, write_o
    );

endinterface

// File: rtl/l2_cacheline_adaptor.sv
// Converts whole-line L2 read/write requests into 4-beat 64-bit memory bursts
// and returns a single-cycle response when the burst completes.
module l2_cacheline_adaptor
    import l2_adaptor_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    l2_cacheline_adaptor_if.slave  bus
);

    adaptor_state_e         state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [LINE_WIDTH-1:0]  buf_q, buf_d;
    logic                   read_q, read_d;
    logic                   write_q, write_d;
    logic                   resp_q, resp_d;
    logic [BURST_WIDTH-1:0] beat_sel;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        buf_d   = buf_q;

        unique case (state_q)
            IDLE: begin
                // Read wins if both requests are (illegally) raised together
                if (bus.read_i) begin
                    addr_d  = bus.address_i;
                    cnt_d   = '0;
                    state_d = READ;
                end else if (bus.write_i) begin
                    addr_d  = bus.address_i;
                    buf_d   = bus.line_i;
                    cnt_d   = '0;
                    state_d = WRITE;
                end
            end
            READ: begin
                if (bus.resp_i) begin
                    for (int b = 0; b < BEATS; b++) begin
                        if (cnt_q == CNT_W'(b)) begin
                            buf_d[b*BURST_WIDTH +: BURST_WIDTH] = bus.burst_i;
                        end
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(BEATS - 1)) state_d = DONE;
                end
            end
            WRITE: begin
                if (bus.resp_i) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(BEATS - 1)) state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Control outputs are registered decodes of the next state
        read_d  = (state_d == READ);
        write_d = (state_d == WRITE);
        resp_d  = (state_d == DONE);
    end

    // Write beat currently addressed by the counter
    always_comb begin
        beat_sel = '0;
        for (int b = 0; b < BEATS; b++) begin
            if (cnt_q == CNT_W'(b)) beat_sel = buf_q[b*BURST_WIDTH +: BURST_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            buf_q   <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            resp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            buf_q   <= buf_d;
            read_q  <= read_d;
            write_q <= write_d;
            resp_q  <= resp_d;
        end
    end

    assign bus.line_o    = buf_q;
    assign bus.address_o = addr_q;
    assign bus.burst_o   = beat_sel;
    assign bus.read_o    = read_q;
    assign bus.write_o   = write_q;
    assign bus.resp_o    = resp_q;

endmodule

// File: doc/l2_cacheline_adaptor.md
# l2_cacheline_adaptor

Memory-side responder for the L2 cache controller's physical-memory port. It accepts a whole-line read or write request (pmem_read/pmem_write with a 256-bit line) and converts it into a 4-beat, 64-bit burst transaction on the main-memory bus. It raises a single-cycle response back to the L2 when the burst completes. It sits between the L2 cache datapath/control and the DRAM model.

## Interface
- LINE_WIDTH, 256, cache line width in bits
- BURST_WIDTH, 64, memory bus width per beat; BEATS = LINE_WIDTH/BURST_WIDTH = 4
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- line_i  in  LINE_WIDTH  line to write (from L2 data array)
- line_o  out  LINE_WIDTH  assembled line from last completed read
- address_i  in  32  line address from L2 (low 5 bits expected zero, passed through unmodified)
- read_i  in  1  L2 pmem_read
- write_i  in  1  L2 pmem_write
- resp_o  out  1  L2 pmem_resp, one-cycle pulse
- burst_i  in  BURST_WIDTH  read beat from memory
- burst_o  out  BURST_WIDTH  write beat to memory
- address_o  out  32  latched line address to memory
- read_o  out  1  burst read request
- write_o  out  1  burst write request
- resp_i  in  1  memory beat-valid/accept, one per beat

## Operation
- States: IDLE, READ, WRITE, DONE. 2-bit beat counter `cnt`, 32-bit address register, LINE_WIDTH line buffer.
- IDLE: read_i sampled high -> latch address_i, cnt=0, go READ. Else write_i high -> latch address_i and line_i into buffer, cnt=0, go WRITE. Both high -> read wins, because simultaneous assertion is an L2 protocol violation. resp_i ignored.
- READ: read_o=1. On each cycle with resp_i=1: buffer[cnt*64 +: 64] <= burst_i, cnt++. Beat with cnt==3 -> go DONE.
- WRITE: write_o=1; burst_o = buffer[cnt*64 +: 64] combinationally. Each cycle with resp_i=1 counts one beat accepted, cnt++. Beat with cnt==3 -> go DONE.
- DONE: resp_o=1 for exactly this cycle; read_i/write_i ignored (L2 still holds its request this cycle); go IDLE.
- line_o = buffer contents, continuously driven. Valid in DONE after a read. Holds until the next read beat or write latch overwrites it.
- address_o = address register in all states. burst_o = selected beat in all states; it is only meaningful while write_o=1.
- Counter wraps 3->0 on the last beat; no beat beyond 4 is accepted.

## Timing
- Reset (any state, including mid-burst): state=IDLE, cnt=0, buffer=0, address=0 at the next edge. resp_o/read_o/write_o=0, line_o=0, burst_o=0, address_o=0. An in-flight burst is abandoned; the memory model is reset alongside.
- All control outputs are Moore (state-decoded).
- Read latency: read_i sampled at edge 0; read_o high from cycle 1. With resp_i high on cycles 1–4, resp_o=1 in cycle 5 and read_o=0 in cycle 5.
- Write: same timing. Beat k is driven on burst_o during the cycle in which cnt==k, and advances only when resp_i is sampled high.
- Gaps: resp_i may deassert between beats; the adaptor holds read_o/write_o and cnt until resp_i returns.
- Back-to-back: L2 WriteBack→Allocate gives write_i then read_i. The adaptor is in IDLE the cycle after DONE and accepts the read with no extra bubble beyond DONE.

## Structure
- Shared package `l2_adaptor_pkg`: LINE_WIDTH, BURST_WIDTH, BEATS constants and the state enum (IDLE, READ, WRITE, DONE).
- Single flat module; no sub-module. Counter and buffer are inline.

## Test plan
- Reset, then IDLE with no requests: read_o/write_o/resp_o stay 0 and line_o=0 for 10 cycles.
- Read 0x0000_1000; memory returns 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive cycles. Required: address_o=0x1000, resp_o pulses once, line_o = {0x44..,0x33..,0x22..,0x11..}, read_o drops with resp_o.
- Write 0x0000_2020 with line_i = {D3,D2,D1,D0}; memory asserts resp_i with one idle cycle between beats. Required: burst_o sequence D0,D1,D2,D3, each held through its gap; write_o held; single resp_o after D3.
- Writeback then allocate to the same index: write beats, DONE, then read accepted in the next cycle. Required: no lost beat and two separate resp_o pulses.
- rst asserted after beat 2 of a read. Required: IDLE next cycle, read_o=0, line_o=0. A subsequent read completes normally with correct data.
- read_i and write_i high together. Required: read burst performed (read_o=1, write_o=0).
